pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the 5-stage MIPS core. It sits ahead of the IF/ID register and supplies the fetch address and instruction-memory enable. Sequential fetch is extended with the following, in fixed priority:
- flush redirect (exception/eret target)
- branch/jump redirect
- a one-entry pending-branch buffer, so a redirect that arrives during a fetch stall is not lost
- a misalignment flag

## Interface
- AW, 32: address width in bits; minimum 3.
- STALL_W, 6: width of the ctrl stall vector; bit 0 is the PC stage.
- RESET_VEC, 0 (AW bits): fetch address loaded by reset.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stop  in  STALL_W  stall vector from ctrl; only stop[0] is used (`Stop` holds the PC).
- flush  in  1  pipeline flush; forces redirect to new_pc.
- new_pc  in  AW  flush target.
- branch_flag  in  1  taken branch/jump resolved in ID.
- branch_target  in  AW  branch/jump target.
- en  out  1  instruction-memory chip enable.
- pc  out  AW  current fetch address.
- pend  out  1  pending-branch buffer occupied.
- addr_err  out  1  current pc is not word-aligned.

## Operation
- en register:
  - rst_n=0 -> en<=0.
  - Otherwise en<=1.
- pc/pend update, first matching rule wins:
  1. rst_n=0 -> pc<=RESET_VEC, pend<=0, pend_tgt<=0.
  2. en=0 (boot cycle) -> pc<=RESET_VEC; pend unchanged.
  3. flush=1 -> pc<=new_pc, pend<=0. Applies regardless of stop[0] and branch_flag.
  4. stop[0]=`Stop`:
     - pc holds.
     - If branch_flag=1: pend<=1, pend_tgt<=branch_target. A newer branch overwrites an occupied buffer.
  5. branch_flag=1 -> pc<=branch_target, pend<=0. A live branch beats a pending one.
  6. pend=1 -> pc<=pend_tgt, pend<=0.
  7. Otherwise -> pc<=pc+4, wrapping modulo 2^AW.
- addr_err = en & (pc[1:0]!=0), combinational from registers. Misaligned targets are loaded unchanged; exception handling belongs to the flagging stage downstream.
- Bits of stop other than bit 0 are ignored.

## Timing
- Reset values: en=0, pc=RESET_VEC, pend=0, addr_err=0.
- Reset release:
  - First edge with rst_n=1 -> en=1, pc=RESET_VEC.
  - Next unstalled edge -> RESET_VEC+4.
- Latencies:
  - Redirect (flush or branch): pc shows the target exactly one edge after the input is sampled.
  - Pending branch: applied on the first edge where stop[0]=`NoStop`, i.e. one cycle after the stall is released.
- Simultaneous events:
  - flush with stall -> flush wins and the buffer clears.
  - branch with stall -> branch is buffered and pc holds.
  - Stall release with a live branch while pend=1 -> live target used, buffer cleared.
- Reset mid-operation: at the first rst_n=0 edge, en drops, pc returns to RESET_VEC and pend clears, whatever else is asserted.
- Wrap-around: pc=2^AW-4 with no redirect -> 0 on the next edge; no flag is raised.

## Structure
- Shared constants in define.v:
  - `Stop` / `NoStop`
  - `DataWidth` as the default for AW
  - `ResetVec` as the default for RESET_VEC
- Single flat module with no sub-module. The redirect priority mux and the pending buffer are kept in one always block for the pc path, plus a separate one for en.

## Test plan
- Reset then free-run:
  - rst_n=0 for 3 cycles, then 1 -> en=1 at first edge with pc=0.
  - Then pc=4, 8, 12 on successive edges.
- Branch while running: branch_flag=1, branch_target=0x100 at pc=0x8 -> pc=0x100 next edge, then 0x104.
- Branch during stall:
  - stop=6'b000011 for 3 cycles; branch_flag pulses 1 cycle with target 0x200 -> pend=1 and pc held.
  - Stall released -> pc=0x200 next edge, pend=0.
- Flush beats everything: flush=1, new_pc=0x380 in the same cycle as stop[0]=1, branch_flag=1 and pend=1 -> pc=0x380, pend=0.
- Misalignment and wrap:
  - branch_target=0x102 -> pc=0x102 with addr_err=1.
  - With AW=8, from pc=0xFC -> pc=0x00 with addr_err=0.
- Reset mid-stall: pend=1 with stop[0]=1, then rst_n=0 -> en=0, pc=RESET_VEC, pend=0 at that edge.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and helpers for the fetch program-counter
// generator.
//   STOP / NO_STOP    : values of the PC-stage stall bit (stop[0])
//   DATA_WIDTH        : default fetch address width
//   RESET_VEC_DEF     : default fetch address loaded by reset
//   PC_STEP           : sequential fetch increment in bytes
//   misaligned()      : true when an address is not word-aligned
package pc_gen_pkg;

  localparam logic        STOP          = 1'b1;
  localparam logic        NO_STOP       = 1'b0;
  localparam int          DATA_WIDTH    = 32;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam int          PC_STEP       = 4;

  // A word address must have its two low bits clear.
  function automatic logic misaligned(input logic [1:0] lo_bits);
    return (lo_bits != 2'b00);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: bundle between the pipeline control/ID side and the PC generator.
//   stop, flush, new_pc, branch_flag, branch_target : control -> pc_gen
//   en, pc, pend, addr_err                          : pc_gen -> fetch/pipeline
// master modport is the control side, slave modport is pc_gen.
interface pc_gen_if #(
  parameter int AW      = 32,
  parameter int STALL_W = 6
);

  logic [STALL_W-1:0] stop;
  logic               flush;
  logic [AW-1:0]      new_pc;
  logic               branch_flag;
  logic [AW-1:0]      branch_target;
  logic               en;
  logic [AW-1:0]      pc;
  logic               pend;
  logic               addr_err;

  modport master (
    output stop, flush, new_pc, branch_flag, branch_target,
    input  en, pc, pend, addr_err
  );

  modport slave (
    input  stop, flush, new_pc, branch_flag, branch_target,
    output en, pc, pend, addr_err
  );

endinterface

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator ahead of the IF/ID register.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : pc_gen_if slave (stall/flush/branch in; en/pc/pend/addr_err out)
// Next pc priority: boot cycle, flush, stall (buffers a branch), live branch,
// pending branch, sequential pc+4 (wraps modulo 2^AW).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int            AW        = DATA_WIDTH,
  parameter int            STALL_W   = 6,
  parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF)
) (
  input  logic     clk,
  input  logic     rst_n,
  pc_gen_if.slave  bus
);

  logic          en_q;
  logic [AW-1:0] pc_q,       pc_d;
  logic          pend_q,     pend_d;
  logic [AW-1:0] pend_tgt_q, pend_tgt_d;

  // Only the PC-stage bit of the stall vector matters here.
  logic          stall_s;
  logic          unused_stop_s;

  assign stall_s       = (bus.stop[0] == STOP);
  assign unused_stop_s = ^bus.stop;

  // Redirect priority mux and pending-branch buffer.
  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (!en_q) begin
      // First cycle out of reset: fetch starts at the reset vector.
      pc_d = RESET_VEC;
    end else if (bus.flush) begin
      pc_d   = bus.new_pc;
      pend_d = 1'b0;
    end else if (stall_s) begin
      // pc holds; a branch resolved now must survive the stall.
      if (bus.branch_flag) begin
        pend_d     = 1'b1;
        pend_tgt_d = bus.branch_target;
      end else begin
        pend_d     = pend_q;
      end
    end else if (bus.branch_flag) begin
      // A live branch is younger than any buffered one.
      pc_d   = bus.branch_target;
      pend_d = 1'b0;
    end else if (pend_q) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else begin
      pc_d = pc_q + AW'(PC_STEP);
    end
  end

  // pc path state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_VEC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  // Instruction-memory enable: low only while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  assign bus.en       = en_q;
  assign bus.pc       = pc_q;
  assign bus.pend     = pend_q;
  // Misaligned targets are loaded as-is; the downstream stage raises the fault.
  assign bus.addr_err = en_q & misaligned(pc_q[1:0]);

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test of pc_gen with a spec-level reference model.
// Two instances share clock and reset: a 32-bit one for the redirect paths and
// an 8-bit one with reset vector 0xF0 for address wrap-around.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pc_gen_if #(.AW(32), .STALL_W(6)) ifa ();
  pc_gen_if #(.AW(8),  .STALL_W(6)) ifb ();

  pc_gen #(.AW(32), .STALL_W(6), .RESET_VEC(32'h0000_0000)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  pc_gen #(.AW(8), .STALL_W(6), .RESET_VEC(8'hF0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        en;
    logic [31:0] pc;
    logic        pend;
    logic [31:0] tgt;
  } mstate_t;

  function automatic mstate_t model_step(
    input mstate_t s, input logic rst, input logic stall, input logic fl,
    input logic [31:0] npc, input logic br, input logic [31:0] bt,
    input int aw, input logic [31:0] rv);
    mstate_t n;
    logic [31:0] mask;
    mask = (aw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << aw) - 32'd1);
    n = s;
    n.en = rst;
    if (!rst) begin
      n.pc = rv; n.pend = 1'b0; n.tgt = 32'd0;
    end else if (!s.en) begin
      n.pc = rv;
    end else if (fl) begin
      n.pc = npc & mask; n.pend = 1'b0;
    end else if (stall) begin
      if (br) begin n.pend = 1'b1; n.tgt = bt & mask; end
    end else if (br) begin
      n.pc = bt & mask; n.pend = 1'b0;
    end else if (s.pend) begin
      n.pc = s.tgt; n.pend = 1'b0;
    end else begin
      n.pc = (s.pc + 32'd4) & mask;
    end
    return n;
  endfunction

  mstate_t ma, mb;
  logic    m_valid = 1'b0;

  always @(posedge clk) begin
    ma <= model_step(ma, rst_n, ifa.stop[0], ifa.flush, ifa.new_pc,
                     ifa.branch_flag, ifa.branch_target, 32, 32'h0000_0000);
    mb <= model_step(mb, rst_n, ifb.stop[0], ifb.flush, {24'd0, ifb.new_pc},
                     ifb.branch_flag, {24'd0, ifb.branch_target}, 8, 32'h0000_00F0);
    m_valid <= m_valid | ~rst_n;
  end

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("a.en",       {31'd0, ifa.en},       {31'd0, ma.en});
      chk("a.pc",       ifa.pc,                ma.pc);
      chk("a.pend",     {31'd0, ifa.pend},     {31'd0, ma.pend});
      chk("a.addr_err", {31'd0, ifa.addr_err}, {31'd0, ma.en & (ma.pc[1:0] != 2'b00)});
      chk("b.en",       {31'd0, ifb.en},       {31'd0, mb.en});
      chk("b.pc",       {24'd0, ifb.pc},       mb.pc);
      chk("b.pend",     {31'd0, ifb.pend},     {31'd0, mb.pend});
      chk("b.addr_err", {31'd0, ifb.addr_err}, {31'd0, mb.en & (mb.pc[1:0] != 2'b00)});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [5:0] st, input logic fl, input logic [31:0] npc,
                         input logic br, input logic [31:0] bt);
    ifa.stop = st; ifa.flush = fl; ifa.new_pc = npc;
    ifa.branch_flag = br; ifa.branch_target = bt;
  endtask

  task automatic chk_a(input string nm, input logic [31:0] pc_e, input logic pend_e,
                       input logic err_e);
    chk({nm, ".pc"},       ifa.pc,                pc_e);
    chk({nm, ".pend"},     {31'd0, ifa.pend},     {31'd0, pend_e});
    chk({nm, ".addr_err"}, {31'd0, ifa.addr_err}, {31'd0, err_e});
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    ifb.stop = 6'b000000; ifb.flush = 1'b0; ifb.new_pc = 8'h00;
    ifb.branch_flag = 1'b0; ifb.branch_target = 8'h00;

    repeat (3) tick();
    chk("rst.a.en", {31'd0, ifa.en}, 32'd0);
    chk_a("rst.a", 32'h0, 1'b0, 1'b0);
    chk("rst.b.en", {31'd0, ifb.en}, 32'd0);
    chk("rst.b.pc", {24'd0, ifb.pc}, 32'hF0);

    rst_n = 1'b1;
    tick();
    chk("boot.a.en", {31'd0, ifa.en}, 32'd1);
    chk_a("boot.a", 32'h0, 1'b0, 1'b0);
    chk("boot.b.pc", {24'd0, ifb.pc}, 32'hF0);
    tick();  chk_a("seq1", 32'h4, 1'b0, 1'b0);
    tick();  chk_a("seq2", 32'h8, 1'b0, 1'b0);

    // Branch while running.
    drive_a(6'b000000, 1'b0, 32'h0, 1'b1, 32'h100);
    tick();  chk_a("br", 32'h100, 1'b0, 1'b0);
    chk("wrap.b.pc_fc", {24'd0, ifb.pc}, 32'hFC);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("br.next", 32'h104, 1'b0, 1'b0);
    chk("wrap.b.pc_00", {24'd0, ifb.pc}, 32'h00);
    chk("wrap.b.addr_err", {31'd0, ifb.addr_err}, 32'd0);

    // Branch during a 3-cycle stall.
    drive_a(6'b000011, 1'b0, 32'h0, 1'b1, 32'h200);
    tick();  chk_a("stall.br", 32'h104, 1'b1, 1'b0);
    drive_a(6'b000011, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("stall.hold1", 32'h104, 1'b1, 1'b0);
    tick();  chk_a("stall.hold2", 32'h104, 1'b1, 1'b0);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("stall.release", 32'h200, 1'b0, 1'b0);
    tick();  chk_a("stall.next", 32'h204, 1'b0, 1'b0);

    // Flush beats stall, live branch and a full buffer.
    drive_a(6'b000001, 1'b0, 32'h0, 1'b1, 32'h300);
    tick();  chk_a("fl.setup", 32'h204, 1'b1, 1'b0);
    drive_a(6'b000001, 1'b1, 32'h380, 1'b1, 32'h340);
    tick();  chk_a("fl", 32'h380, 1'b0, 1'b0);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("fl.next", 32'h384, 1'b0, 1'b0);

    // Stall release with a live branch while pending: live target wins.
    drive_a(6'b000001, 1'b0, 32'h0, 1'b1, 32'h400);
    tick();  chk_a("live.setup", 32'h384, 1'b1, 1'b0);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b1, 32'h500);
    tick();  chk_a("live", 32'h500, 1'b0, 1'b0);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("live.next", 32'h504, 1'b0, 1'b0);

    // Upper stall bits are ignored.
    drive_a(6'b111110, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("stopbits", 32'h508, 1'b0, 1'b0);

    // Misaligned target loaded unchanged and flagged.
    drive_a(6'b000000, 1'b0, 32'h0, 1'b1, 32'h102);
    tick();  chk_a("mis", 32'h102, 1'b0, 1'b1);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("mis.next", 32'h106, 1'b0, 1'b1);

    // Reset in the middle of a stall with a pending branch.
    drive_a(6'b000001, 1'b0, 32'h0, 1'b1, 32'h600);
    tick();  chk_a("mrst.setup", 32'h106, 1'b1, 1'b1);
    drive_a(6'b000001, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    tick();
    chk("mrst.en", {31'd0, ifa.en}, 32'd0);
    chk_a("mrst", 32'h0, 1'b0, 1'b0);

    // Boot cycle ignores a flush.
    rst_n = 1'b1;
    drive_a(6'b000000, 1'b1, 32'h700, 1'b0, 32'h0);
    tick();
    chk("reboot.en", {31'd0, ifa.en}, 32'd1);
    chk_a("reboot", 32'h0, 1'b0, 1'b0);
    drive_a(6'b000000, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();  chk_a("reboot.next", 32'h4, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
